// File: rtl/ct_lsu_spsram_512x7_arb.sv
// 512x7 single-port SRAM front end: zero-fills the array after reset or flush, then grants
// one read or write per cycle (writes first, reads promoted after STARVE_LIMIT denials).
module ct_lsu_spsram_512x7_arb #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic       forever_cpuclk,
  input  logic       cpurst_b,
  input  logic       flush_req,
  input  logic       rd_req,
  input  logic [8:0] rd_idx,
  output logic       rd_grant,
  output logic       rd_data_vld,
  output logic [6:0] rd_data,
  input  logic       wr_req,
  input  logic [8:0] wr_idx,
  input  logic [6:0] wr_data,
  input  logic [6:0] wr_mask,
  output logic       wr_grant,
  output logic       init_done,
  output logic [8:0] sram_a,
  output logic       sram_cen,
  output logic       sram_gwen,
  output logic [6:0] sram_wen,
  output logic [6:0] sram_d,
  input  logic [6:0] sram_q
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [1:0] LP_STARVE = 2'(STARVE_LIMIT);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [8:0] r_init_cnt;
  logic [1:0] r_starve_cnt;
  logic       r_init_done;
  logic       r_rd_data_vld;
  logic       w_rd_pri;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) r_state <= ST_INIT;
    else           r_state <= w_state_nxt;
  end

  // A flush arriving on the last init cycle restarts the fill rather than leaving INIT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (!flush_req && r_init_cnt == 9'd511) w_state_nxt = ST_RUN;
      ST_RUN:  if (flush_req) w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_init_cnt    <= '0;
      r_starve_cnt  <= '0;
      r_init_done   <= 1'b0;
      r_rd_data_vld <= 1'b0;
    end else begin
      r_init_done   <= (w_state_nxt == ST_RUN);
      r_rd_data_vld <= rd_grant;
      if (r_state == ST_INIT && !flush_req) r_init_cnt <= r_init_cnt + 9'd1;
      else                                  r_init_cnt <= '0;
      if (r_state == ST_INIT || rd_grant)
        r_starve_cnt <= '0;
      else if (rd_req && r_starve_cnt != LP_STARVE)
        r_starve_cnt <= r_starve_cnt + 2'd1;
    end
  end

  assign w_rd_pri = (r_starve_cnt == LP_STARVE);

  always_comb begin
    rd_grant  = 1'b0;
    wr_grant  = 1'b0;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = 7'h7f;
    sram_a    = '0;
    sram_d    = '0;
    case (r_state)
      ST_INIT: begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = 7'h00;
        sram_a    = r_init_cnt;
      end
      ST_RUN: begin
        rd_grant = rd_req & (w_rd_pri | ~wr_req);
        wr_grant = wr_req & ~rd_grant;
        if (rd_grant) begin
          sram_cen = 1'b0;
          sram_a   = rd_idx;
        end else if (wr_grant) begin
          sram_cen  = 1'b0;
          sram_gwen = 1'b0;
          sram_wen  = ~wr_mask;
          sram_a    = wr_idx;
          sram_d    = wr_data;
        end
      end
    endcase
  end

  assign init_done   = r_init_done;
  assign rd_data_vld = r_rd_data_vld;
  assign rd_data     = r_rd_data_vld ? sram_q : 7'h00;

endmodule
